// File: rtl/char_move_ctrl.sv
// Overworld character movement controller: decodes WASD keycodes into a facing and
// runs the turn/walk sequence on frame ticks, feeding the frame drawer's motion inputs.
module char_move_ctrl #(
    parameter logic [3:0] OVERWORLD_STATE = 4'd1,
    parameter int         TURN_FRAMES     = 4,
    parameter int         WALK_ANIM_DIV   = 8,
    parameter int         RUN_ANIM_DIV    = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_tick,
    input  logic [7:0] keycode,
    input  logic       run_held,
    input  logic [3:0] state_num,
    input  logic       atTile,
    output logic       charIsMoving,
    output logic       charIsRunning,
    output logic [1:0] direction,
    output logic [1:0] charMoveFrame
);

    localparam logic [3:0] TURN_N = 4'(TURN_FRAMES);
    localparam logic [3:0] WALK_N = 4'(WALK_ANIM_DIV);
    localparam logic [3:0] RUN_N  = 4'(RUN_ANIM_DIV);

    typedef enum logic [1:0] {S_IDLE, S_TURN, S_WALK} state_t;

    state_t     state;
    logic [3:0] turn_cnt;
    logic [3:0] anim_cnt;
    logic       moved;

    logic [1:0] key_dir;
    logic       key_dir_ok;
    logic       key_valid;
    logic       same_key;
    logic [3:0] anim_div;
    logic [3:0] anim_next;

    always_comb begin
        key_dir    = 2'd0;
        key_dir_ok = 1'b1;
        case (keycode)
            8'h1A:   key_dir = 2'd1;
            8'h16:   key_dir = 2'd0;
            8'h04:   key_dir = 2'd2;
            8'h07:   key_dir = 2'd3;
            default: key_dir_ok = 1'b0;
        endcase
    end

    assign key_valid = key_dir_ok && (state_num == OVERWORLD_STATE);
    assign same_key  = key_valid && (key_dir == direction);
    assign anim_div  = charIsRunning ? RUN_N : WALK_N;
    assign anim_next = anim_cnt + 4'd1;

    // A chained step can switch from the walk to the run divider mid-count, so the
    // divider compare uses >= to avoid running the counter past the smaller limit.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state         <= S_IDLE;
            turn_cnt      <= 4'd0;
            anim_cnt      <= 4'd0;
            moved         <= 1'b0;
            charIsMoving  <= 1'b0;
            charIsRunning <= 1'b0;
            direction     <= 2'd0;
            charMoveFrame <= 2'd0;
        end else if (frame_tick) begin
            case (state)
                S_IDLE: begin
                    charIsMoving  <= 1'b0;
                    charMoveFrame <= 2'd0;
                    if (key_valid) begin
                        if (key_dir != direction) begin
                            state     <= S_TURN;
                            direction <= key_dir;
                            turn_cnt  <= 4'd0;
                        end else begin
                            state         <= S_WALK;
                            charIsMoving  <= 1'b1;
                            charIsRunning <= run_held;
                            anim_cnt      <= 4'd0;
                            moved         <= 1'b0;
                        end
                    end
                end
                S_TURN: begin
                    turn_cnt <= turn_cnt + 4'd1;
                    if (turn_cnt + 4'd1 >= TURN_N) begin
                        state <= S_IDLE;
                    end
                end
                S_WALK: begin
                    moved <= 1'b1;
                    if (anim_next >= anim_div) begin
                        anim_cnt      <= 4'd0;
                        charMoveFrame <= charMoveFrame + 2'd1;
                    end else begin
                        anim_cnt <= anim_next;
                    end
                    // atTile is still high on the first tick of a step; only trust it once moved
                    if (moved && atTile) begin
                        if (same_key) begin
                            charIsRunning <= run_held;
                        end else begin
                            state         <= S_IDLE;
                            charIsMoving  <= 1'b0;
                            charIsRunning <= 1'b0;
                            charMoveFrame <= 2'd0;
                            anim_cnt      <= 4'd0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_move_ctrl.sv
// Directed bench for char_move_ctrl: turn, walk, run, chained step, state exit and reset.
module tb_char_move_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_tick = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       run_held = 1'b0;
    logic [3:0] state_num = 4'd1;
    logic       atTile = 1'b0;
    logic       charIsMoving;
    logic       charIsRunning;
    logic [1:0] direction;
    logic [1:0] charMoveFrame;

    int n_chk  = 0;
    int n_fail = 0;

    char_move_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_tick   (frame_tick),
        .keycode      (keycode),
        .run_held     (run_held),
        .state_num    (state_num),
        .atTile       (atTile),
        .charIsMoving (charIsMoving),
        .charIsRunning(charIsRunning),
        .direction    (direction),
        .charMoveFrame(charMoveFrame)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One frame: frame_tick high for exactly one Clk, then returns on a falling edge.
    task automatic tick();
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        @(negedge Clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_moving",  {7'd0, charIsMoving},  8'd0);
        chk("rst_running", {7'd0, charIsRunning}, 8'd0);
        chk("rst_dir",     {6'd0, direction},     8'd0);
        chk("rst_frame",   {6'd0, charMoveFrame}, 8'd0);
        Reset = 1'b1;
        @(negedge Clk);

        // Key pulse between ticks must not be seen
        keycode = 8'h07;
        @(negedge Clk);
        keycode = 8'h00;
        tick();
        chk("glitch_dir",    {6'd0, direction},    8'd0);
        chk("glitch_moving", {7'd0, charIsMoving}, 8'd0);

        // Turn down -> right, then walk from tick 6
        keycode = 8'h07;
        tick();
        chk("turn_dir_t1",    {6'd0, direction},    8'd3);
        chk("turn_moving_t1", {7'd0, charIsMoving}, 8'd0);
        for (int t = 2; t <= 5; t++) begin
            tick();
            chk($sformatf("turn_moving_t%0d", t), {7'd0, charIsMoving}, 8'd0);
        end
        for (int t = 6; t <= 10; t++) begin
            tick();
            chk($sformatf("turn_moving_t%0d", t), {7'd0, charIsMoving}, 8'd1);
        end
        keycode = 8'h00;
        atTile  = 1'b1;
        tick();
        chk("turn_end_moving", {7'd0, charIsMoving}, 8'd0);
        atTile = 1'b0;

        // Face down again
        keycode = 8'h16;
        tick();
        chk("face_down_dir", {6'd0, direction}, 8'd0);
        ticks(4);
        chk("face_down_idle", {7'd0, charIsMoving}, 8'd0);

        // Walk: start tick, then WALK ticks numbered from 1
        atTile   = 1'b1;
        run_held = 1'b0;
        tick();
        chk("walk_start_moving",  {7'd0, charIsMoving},  8'd1);
        chk("walk_start_running", {7'd0, charIsRunning}, 8'd0);
        atTile = 1'b0;
        ticks(7);
        chk("walk_frame_w7", {6'd0, charMoveFrame}, 8'd0);
        tick();
        chk("walk_frame_w8", {6'd0, charMoveFrame}, 8'd1);
        ticks(7);
        chk("walk_frame_w15",  {6'd0, charMoveFrame}, 8'd1);
        chk("walk_moving_w15", {7'd0, charIsMoving},  8'd1);
        keycode = 8'h00;
        atTile  = 1'b1;
        tick();
        chk("walk_end_moving", {7'd0, charIsMoving},  8'd0);
        chk("walk_end_frame",  {6'd0, charMoveFrame}, 8'd0);

        // Run: atTile left high with key released on WALK tick 1 must be ignored
        keycode  = 8'h16;
        run_held = 1'b1;
        tick();
        chk("run_start_running", {7'd0, charIsRunning}, 8'd1);
        keycode = 8'h00;
        tick();
        chk("run_first_tile_ignored", {7'd0, charIsMoving}, 8'd1);
        atTile = 1'b0;
        ticks(2);
        chk("run_frame_r3", {6'd0, charMoveFrame}, 8'd0);
        tick();
        chk("run_frame_r4", {6'd0, charMoveFrame}, 8'd1);
        ticks(4);
        chk("run_frame_r8", {6'd0, charMoveFrame}, 8'd2);
        ticks(4);
        chk("run_frame_r12", {6'd0, charMoveFrame}, 8'd3);
        ticks(3);
        chk("run_frame_r15", {6'd0, charMoveFrame}, 8'd3);
        tick();
        chk("run_frame_wrap_r16", {6'd0, charMoveFrame}, 8'd0);
        atTile = 1'b1;
        tick();
        chk("run_end_moving",  {7'd0, charIsMoving},  8'd0);
        chk("run_end_running", {7'd0, charIsRunning}, 8'd0);

        // Chained step: walk 9 ticks, raise run_held, hold key through the tile
        keycode  = 8'h16;
        run_held = 1'b0;
        tick();
        chk("chain_start_running", {7'd0, charIsRunning}, 8'd0);
        atTile = 1'b0;
        ticks(8);
        chk("chain_frame_c8", {6'd0, charMoveFrame}, 8'd1);
        run_held = 1'b1;
        tick();
        chk("chain_running_before_tile", {7'd0, charIsRunning}, 8'd0);
        atTile = 1'b1;
        tick();
        chk("chain_moving",  {7'd0, charIsMoving},  8'd1);
        chk("chain_running", {7'd0, charIsRunning}, 8'd1);
        chk("chain_frame",   {6'd0, charMoveFrame}, 8'd1);
        atTile = 1'b0;
        ticks(2);
        chk("chain_run_frame_c12", {6'd0, charMoveFrame}, 8'd2);
        keycode = 8'h00;
        atTile  = 1'b1;
        tick();
        chk("chain_end_moving", {7'd0, charIsMoving}, 8'd0);

        // State exit mid-step
        keycode  = 8'h16;
        run_held = 1'b0;
        tick();
        atTile = 1'b0;
        tick();
        state_num = 4'd2;
        ticks(2);
        chk("exit_still_moving", {7'd0, charIsMoving}, 8'd1);
        atTile = 1'b1;
        tick();
        chk("exit_idle_moving", {7'd0, charIsMoving}, 8'd0);
        atTile  = 1'b0;
        keycode = 8'h04;
        tick();
        chk("exit_no_turn_t1", {6'd0, direction}, 8'd0);
        ticks(5);
        chk("exit_no_turn_t6",    {6'd0, direction},    8'd0);
        chk("exit_no_move_t6",    {7'd0, charIsMoving}, 8'd0);
        state_num = 4'd1;

        // Reset mid-walk: face right, walk to charMoveFrame = 2
        keycode = 8'h07;
        ticks(6);
        chk("pre_rst_moving", {7'd0, charIsMoving}, 8'd1);
        ticks(16);
        chk("pre_rst_frame", {6'd0, charMoveFrame}, 8'd2);
        chk("pre_rst_dir",   {6'd0, direction},     8'd3);
        #2 Reset = 1'b0;
        #1;
        chk("async_rst_moving",  {7'd0, charIsMoving},  8'd0);
        chk("async_rst_running", {7'd0, charIsRunning}, 8'd0);
        chk("async_rst_dir",     {6'd0, direction},     8'd0);
        chk("async_rst_frame",   {6'd0, charMoveFrame}, 8'd0);
        tick();
        chk("held_rst_moving", {7'd0, charIsMoving}, 8'd0);
        Reset   = 1'b1;
        keycode = 8'h00;
        tick();
        chk("post_rst_dir", {6'd0, direction}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
